// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: internal byte-lane data memory with fault detection,
// WB pipeline registers, load formatting and replay of held read data across stalls.
module mem_wb_stage #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int RD_W        = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            clear,
    input  logic [XLEN-1:0] addr_ME,
    input  logic [XLEN-1:0] w_data_ME,
    input  logic            mem_read_ME,
    input  logic            mem_write_ME,
    input  logic [2:0]      mem_op_ME,
    input  logic [XLEN-1:0] result_ME,
    input  logic [RD_W-1:0] rd_ME,
    input  logic            reg_write_ME,
    output logic [XLEN-1:0] result_WB,
    output logic [RD_W-1:0] rd_WB,
    output logic            reg_write_WB,
    output logic [XLEN-1:0] wb_data,
    output logic            fault_WB
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [XLEN-1:0] mem_rdata_q;

    logic [AW-1:0]   word_idx;
    logic [1:0]      offset_ME;
    logic            op_legal;
    logic            misaligned;
    logic            fault_ME;
    logic            store_en;
    logic [3:0]      lane_en;
    logic [XLEN-1:0] store_data;
    logic            unused_addr;

    logic [XLEN-1:0] result_d, result_q;
    logic [RD_W-1:0] rd_d, rd_q;
    logic [2:0]      op_d, op_q;
    logic [1:0]      offset_d, offset_q;
    logic            mem_read_d, mem_read_q;
    logic            reg_write_d, reg_write_q;
    logic            fault_d, fault_q;
    logic            stall_d, stall_q;
    logic [XLEN-1:0] hold_d, hold_q;

    logic [XLEN-1:0] raw_word;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;

    assign unused_addr = ^addr_ME[XLEN-1:AW+2];

    always_comb begin
        word_idx   = addr_ME[AW+1:2];
        offset_ME  = addr_ME[1:0];
        op_legal   = (mem_op_ME == OP_B) || (mem_op_ME == OP_H) || (mem_op_ME == OP_W) ||
                     (mem_op_ME == OP_BU) || (mem_op_ME == OP_HU);
        misaligned = ((mem_op_ME[1:0] == 2'b01) && offset_ME[0]) ||
                     ((mem_op_ME == OP_W) && (offset_ME != 2'b00));
        fault_ME   = (mem_read_ME | mem_write_ME) & (~op_legal | misaligned);
        store_en   = en & ~clear & mem_write_ME & ~fault_ME;
        case (mem_op_ME[1:0])
            2'b00:   lane_en = 4'b0001 << offset_ME;
            2'b01:   lane_en = offset_ME[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
        store_data = w_data_ME << {offset_ME, 3'b000};
    end

    // Memory is not reset; the read register samples old data on a same-word store.
    always_ff @(posedge clk) begin
        mem_rdata_q <= mem[word_idx];
        if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        raw_word    = stall_q ? hold_q : mem_rdata_q;
        result_d    = result_q;
        rd_d        = rd_q;
        op_d        = op_q;
        offset_d    = offset_q;
        mem_read_d  = mem_read_q;
        reg_write_d = reg_write_q;
        fault_d     = fault_q;
        stall_d     = stall_q;
        hold_d      = hold_q;
        if (en) begin
            stall_d = 1'b0;
            if (clear) begin
                result_d    = '0;
                rd_d        = '0;
                op_d        = '0;
                offset_d    = '0;
                mem_read_d  = 1'b0;
                reg_write_d = 1'b0;
                fault_d     = 1'b0;
            end else begin
                result_d    = result_ME;
                rd_d        = rd_ME;
                op_d        = mem_op_ME;
                offset_d    = offset_ME;
                mem_read_d  = mem_read_ME;
                reg_write_d = reg_write_ME & ~fault_ME;
                fault_d     = fault_ME;
            end
        end else begin
            // Freeze the word the WB load is using so later memory reads cannot disturb it.
            stall_d = 1'b1;
            hold_d  = raw_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            rd_q        <= '0;
            op_q        <= '0;
            offset_q    <= '0;
            mem_read_q  <= 1'b0;
            reg_write_q <= 1'b0;
            fault_q     <= 1'b0;
            stall_q     <= 1'b0;
            hold_q      <= '0;
        end else begin
            result_q    <= result_d;
            rd_q        <= rd_d;
            op_q        <= op_d;
            offset_q    <= offset_d;
            mem_read_q  <= mem_read_d;
            reg_write_q <= reg_write_d;
            fault_q     <= fault_d;
            stall_q     <= stall_d;
            hold_q      <= hold_d;
        end
    end

    always_comb begin
        shifted = raw_word >> {offset_q, 3'b000};
        case (op_q)
            OP_B:    load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            OP_H:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            OP_BU:   load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            OP_HU:   load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_data = raw_word;
        endcase
        wb_data = (mem_read_q & ~fault_q) ? load_data : result_q;
    end

    assign result_WB    = result_q;
    assign rd_WB        = rd_q;
    assign reg_write_WB = reg_write_q;
    assign fault_WB     = fault_q;

endmodule
